caesar_sram_streamer: RTL and testbench

CAESAR_SRAM_STREAMER -- requirements
Module: caesar_sram_streamer

---
 rtl/caesar_sram_streamer_pkg.sv | 7 +
 rtl/caesar_stream_fifo.sv | 51 +++++
 rtl/caesar_sram_streamer.sv | 102 ++++++++++
 tb/tb_caesar_sram_streamer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/caesar_sram_streamer_pkg.sv
// caesar_sram_streamer_pkg: shared widths and FSM state encoding for the SRAM streamer
package caesar_sram_streamer_pkg;
  localparam int AddrWidth = 12;
  localparam int LenWidth  = 13;
  localparam int DataWidth = 32;
  typedef enum logic [2:0] {IDLE, WRITE, READ, FLUSH, DONE} state_e;
endpackage

// File: rtl/caesar_stream_fifo.sv
// caesar_stream_fifo: small read-return buffer (DEPTH 2..4) with occupancy count
module caesar_stream_fifo
  import caesar_sram_streamer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = DataWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [2:0]       count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic do_push, do_pop;
  // Pointer/count update; overflowing pushes and underflowing pops are ignored
  always_comb begin
    full_o   = count_q == 3'(DEPTH);
    empty_o  = count_q == 3'd0;
    count_o  = count_q;
    data_o   = mem_q[rd_ptr_q];
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = data_i;
    wr_ptr_d = !do_push ? wr_ptr_q : wr_ptr_q == 2'(DEPTH-1) ? 2'd0 : wr_ptr_q + 2'd1;
    rd_ptr_d = !do_pop ? rd_ptr_q : rd_ptr_q == 2'(DEPTH-1) ? 2'd0 : rd_ptr_q + 2'd1;
    count_d  = count_q + 3'(do_push) - 3'(do_pop);
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/caesar_sram_streamer.sv
// caesar_sram_streamer: streams words into or out of a single-port SRAM bank
module caesar_sram_streamer
  import caesar_sram_streamer_pkg::*;
#(
  parameter int NUM_WORDS    = 1024,
  parameter int RD_BUF_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_write_i,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [LenWidth-1:0]  cmd_len_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic [3:0]           wr_be_i,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [DataWidth-1:0] rd_data_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [3:0]           mem_be_o,
  output logic                 mem_set_retentive_no,
  input  logic [DataWidth-1:0] mem_rdata_i,
  input  logic                 retain_req_i,
  output logic                 busy_o,
  output logic                 done_o
);
  state_e state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d, addr_nxt;
  logic [LenWidth-1:0] cnt_q, cnt_d;
  logic inflight_q, inflight_d;
  logic cmd_fire, wr_fire, rd_issue, step, fifo_pop, fifo_full, fifo_empty;
  logic [2:0] fifo_count;
  caesar_stream_fifo #(.DEPTH(RD_BUF_DEPTH), .WIDTH(DataWidth)) u_rd_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inflight_q),
    .pop_i   (fifo_pop),
    .data_i  (mem_rdata_i),
    .data_o  (rd_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );
  // Handshakes and SRAM drive; reads are only issued when the buffer has room for every in-flight word
  always_comb begin
    cmd_ready_o          = state_q == IDLE;
    busy_o               = state_q != IDLE;
    done_o               = state_q == DONE;
    wr_ready_o           = state_q == WRITE;
    rd_valid_o           = (state_q == READ || state_q == FLUSH) && !fifo_empty;
    cmd_fire             = cmd_valid_i && cmd_ready_o;
    wr_fire              = wr_valid_i && wr_ready_o;
    rd_issue             = state_q == READ && !fifo_full && (fifo_count + 3'(inflight_q)) < 3'(RD_BUF_DEPTH);
    fifo_pop             = rd_valid_o && rd_ready_i;
    step                 = wr_fire || rd_issue;
    addr_nxt             = addr_q == AddrWidth'(NUM_WORDS - 1) ? '0 : addr_q + 12'd1;
    mem_req_o            = step;
    mem_we_o             = wr_fire;
    mem_addr_o           = addr_q;
    mem_wdata_o          = wr_fire ? wr_data_i : '0;
    mem_be_o             = wr_fire ? wr_be_i : rd_issue ? 4'hF : 4'h0;
    mem_set_retentive_no = !(state_q == IDLE && retain_req_i && !cmd_valid_i);
  end
  // Next-state, address and remaining-count computation
  always_comb begin
    state_d    = state_q;
    addr_d     = step ? addr_nxt : addr_q;
    cnt_d      = step ? cnt_q - 13'd1 : cnt_q;
    inflight_d = rd_issue;
    case (state_q)
      IDLE: if (cmd_fire) begin
        addr_d  = cmd_addr_i;
        cnt_d   = cmd_len_i;
        state_d = cmd_len_i == '0 ? DONE : cmd_write_i ? WRITE : READ;
      end
      WRITE:   state_d = wr_fire && cnt_q == 13'd1 ? DONE : WRITE;
      READ:    state_d = rd_issue && cnt_q == 13'd1 ? FLUSH : READ;
      FLUSH:   state_d = !inflight_q && fifo_empty ? DONE : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  // Control registers; reset aborts any transfer and forgets in-flight reads
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end
endmodule

// File: tb/tb_caesar_sram_streamer.sv
// tb_caesar_sram_streamer: directed table-driven bench with an SRAM model
module tb_caesar_sram_streamer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [12:0] cmd_len = '0;
  logic wr_valid = 1'b0, wr_ready;
  logic [31:0] wr_data = '0;
  logic [3:0] wr_be = '0;
  logic rd_valid, rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic mem_req, mem_we, mem_ret_n;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  logic retain = 1'b0;
  logic busy, done;
  int tests = 0, fails = 0;
  logic [31:0] sram [4096];
  logic [31:0] ref_mem [4096];

  always #5 clk = ~clk;

  caesar_sram_streamer #(.NUM_WORDS(4096), .RD_BUF_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data), .wr_be_i(wr_be),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_set_retentive_no(mem_ret_n),
    .mem_rdata_i(mem_rdata), .retain_req_i(retain), .busy_o(busy), .done_o(done)
  );

  function automatic logic [31:0] init_f(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] wdata_f(int k, logic [11:0] x);
    return 32'hC0DE0000 ^ (32'(k) << 24) ^ {20'h0, x};
  endfunction

  // SRAM model: request sampled mid-cycle, applied at the edge, read data valid the next cycle
  initial begin
    logic s_req, s_we;
    logic [11:0] s_addr;
    logic [31:0] s_wd;
    logic [3:0] s_be;
    for (int i = 0; i < 4096; i++) sram[i] = init_f(i);
    mem_rdata = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      s_req = mem_req; s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata; s_be = mem_be;
      @(posedge clk);
      if (s_req && s_we)
        for (int b = 0; b < 4; b++) if (s_be[b]) sram[s_addr][8*b +: 8] = s_wd[8*b +: 8];
      mem_rdata <= (s_req && !s_we) ? sram[s_addr] : 32'hDEADBEEF;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input int k, input logic w, input logic [11:0] a, input logic [12:0] l,
                         input logic [3:0] be, input int stall, output int stall_reqs);
    int reqs, pops, cyc, acc_cyc, last_req_cyc, last_pop_cyc, done_cyc;
    logic [11:0] ea, pa;
    logic [31:0] wd;
    bit acc, fin, fire;
    reqs = 0; pops = 0; acc = 0; fin = 0; ea = a; pa = a; stall_reqs = 0;
    acc_cyc = 0; last_req_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    wr_valid = w && l != 0; wr_data = wdata_f(k, a); wr_be = be; rd_ready = stall == 0;
    for (cyc = 0; cyc < 200 + 4 * int'(l) && !fin; cyc++) begin
      @(negedge clk);
      fire = cmd_valid && cmd_ready;
      if (fire) begin acc = 1; acc_cyc = cyc; end
      if (mem_req) begin
        check("mem_addr", mem_addr, ea);
        check("mem_we", mem_we, w);
        check("mem_be", mem_be, w ? be : 4'hF);
        if (w) begin
          wd = wdata_f(k, ea);
          check("mem_wdata", mem_wdata, wd);
          for (int b = 0; b < 4; b++) if (be[b]) ref_mem[ea][8*b +: 8] = wd[8*b +: 8];
        end
        ea = ea + 12'd1; reqs++; last_req_cyc = cyc;
      end else check("mem_idle_zero", {mem_we, mem_be, mem_wdata[26:0]} | 32'(mem_wdata[31:27]), 32'h0);
      if (rd_valid && rd_ready) begin
        check("rd_data", rd_data, ref_mem[pa]);
        pa = pa + 12'd1; pops++; last_pop_cyc = cyc;
      end
      if (done) begin fin = 1; done_cyc = cyc; end
      if (stall > 0 && acc && cyc == acc_cyc + stall) stall_reqs = reqs;
      @(posedge clk); #1;
      if (fire) cmd_valid = 1'b0;
      if (w && mem_req) begin
        wr_data = wdata_f(k, ea);
        if (reqs == int'(l)) wr_valid = 1'b0;
      end
      if (acc && cyc >= acc_cyc + stall) rd_ready = 1'b1;
    end
    cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    check("done_seen", fin, 1'b1);
    check("req_count", reqs, l);
    if (!w) check("pop_count", pops, l);
    if (l == 0) check("len0_done_lat", done_cyc - acc_cyc, 1);
    else if (w) check("wr_done_lat", done_cyc - last_req_cyc, 1);
    else check("rd_done_after_pop", (done_cyc - last_pop_cyc >= 1) && (done_cyc - last_pop_cyc <= 2), 1'b1);
    @(negedge clk);
    check("done_one_cycle", {done, cmd_ready, busy}, 3'b010);
  endtask

  typedef struct {
    logic        w;
    logic [11:0] a;
    logic [12:0] l;
    logic [3:0]  be;
  } vec_t;

  initial begin
    vec_t vecs[9];
    int sr;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int sr;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_f(i);
    vecs[0] = '{1'b1, 12'h010, 13'd4, 4'hF};
    vecs[1] = '{1'b0, 12'h010, 13'd4, 4'hF};
    vecs[2] = '{1'b1, 12'h020, 13'd2, 4'b0101};
    vecs[3] = '{1'b0, 12'h020, 13'd2, 4'hF};
    vecs[4] = '{1'b0, 12'hFFE, 13'd4, 4'hF};
    vecs[5] = '{1'b1, 12'h100, 13'd0, 4'hF};
    vecs[6] = '{1'b0, 12'h100, 13'd0, 4'hF};
    vecs[7] = '{1'b1, 12'hFFF, 13'd3, 4'b1010};
    vecs[8] = '{1'b0, 12'hFFE, 13'd5, 4'hF};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {cmd_ready, busy, done, mem_req, rd_valid, wr_ready, mem_ret_n}, 7'b1000001);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 9; i++) run_cmd(i, vecs[i].w, vecs[i].a, vecs[i].l, vecs[i].be, 0, sr);
    run_cmd(20, 1'b0, 12'h400, 13'd8, 4'hF, 10, sr);
    check("stall_reqs", sr, 2);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h200; cmd_len = 13'd8; rd_ready = 1'b0;
    @(negedge clk);
    check("rst_seq_accept", cmd_ready, 1'b1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_seq_first_read", {mem_req, mem_we, mem_addr}, {2'b10, 12'h200});
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_seq_idle", {cmd_ready, busy, rd_valid, done, mem_req}, 5'b10000);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_seq_quiet", {rd_valid, done, busy}, 3'b000);
    end
    run_cmd(21, 1'b0, 12'h300, 13'd3, 4'hF, 0, sr);
    @(posedge clk); #1 retain = 1'b1;
    @(negedge clk);
    check("retain_idle", mem_ret_n, 1'b0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h050; cmd_len = 13'd0;
    #1 check("retain_cmd_same_cycle", {mem_ret_n, cmd_ready}, 2'b11);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("retain_done", {done, mem_ret_n, mem_req}, 3'b110);
    @(negedge clk);
    check("retain_back_idle", {mem_ret_n, cmd_ready}, 2'b01);
    @(posedge clk); #1 retain = 1'b0;
    @(negedge clk);
    check("retain_released", mem_ret_n, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
